hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//   Register-mapped driver for up to eight active-low seven-segment digits.
//   A small bus writes a nibble per digit plus blank, blink and control
//   registers. The digit pattern is decoded and registered onto hex_out.
//
//   Register map (address):
//     0 VALUE : nibble k drives digit k
//     1 BLANK : bit k forces digit k dark
//     2 BLINK : bit k blinks digit k (reads 0 without the blink option)
//     3 CTRL  : bit0 EN, bit1 LZS (leading-zero suppression),
//               bit2 PHASE_RST (write-only strobe, reads 0)
//
//   Optional feature macro: HEX_DISPLAY_CTRL_BLINK_EN
//     defined   -> blink prescaler/phase and the BLINK register are built
//     undefined -> no prescaler, BLINK reads 0, PHASE_RST does nothing
//
//   Ports:
//     clk        in   single rising-edge clock
//     reset_n    in   asynchronous active-low reset
//     address    in   [1:0] register select
//     write      in   write strobe (one transfer per cycle)
//     writedata  in   [31:0] write data
//     read       in   read strobe
//     readdata   out  [31:0] registered read data, held between reads
//     hex_out    out  [7*NUM_DIGITS-1:0] segments, digit k at [7k+6:7k],
//                     bit0 = segment a ... bit6 = segment g, active-low
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int VW = 4 * NUM_DIGITS;

  logic [VW-1:0]           value_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;
  logic                    en_reg;
  logic                    lzs_reg;
  logic [NUM_DIGITS-1:0]   blink_rd;
  logic [NUM_DIGITS-1:0]   blink_dark;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    zero_run;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic [31:0]             rd_mux;

  logic wr_value;
  logic wr_blank;
  logic wr_ctrl;

  assign wr_value = write && (address == 2'd0);
  assign wr_blank = write && (address == 2'd1);
  assign wr_ctrl  = write && (address == 2'd3);

  // Active-low glyphs, segment a in bit 0.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // -------------------------------------------------------------------------
  // Core registers. Unused upper writedata bits are simply not captured, so
  // they read back as zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= '0;
      blank_reg <= '0;
      en_reg    <= 1'b1;
      lzs_reg   <= 1'b0;
    end else begin
      if (wr_value) value_reg <= writedata[VW-1:0];
      if (wr_blank) blank_reg <= writedata[NUM_DIGITS-1:0];
      if (wr_ctrl) begin
        en_reg  <= writedata[0];
        lzs_reg <= writedata[1];
      end
    end
  end

`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  // -------------------------------------------------------------------------
  // Blink prescaler: counts 0..BLINK_DIV-1 and toggles the phase on each
  // wrap. It free-runs regardless of EN so the blink cadence is not
  // disturbed by disabling the display. PHASE_RST restarts a full visible
  // half-period.
  // -------------------------------------------------------------------------
  localparam int CW = $clog2(BLINK_DIV);

  logic [NUM_DIGITS-1:0] blink_reg;
  logic [CW-1:0]         presc_reg;
  logic                  phase_reg;
  logic                  wr_blink;
  logic                  phase_rst;

  assign wr_blink  = write && (address == 2'd2);
  assign phase_rst = wr_ctrl && writedata[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_reg <= '0;
    end else if (wr_blink) begin
      blink_reg <= writedata[NUM_DIGITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      phase_reg <= 1'b0;
    end else if (phase_rst) begin
      presc_reg <= '0;
      phase_reg <= 1'b0;
    end else if (presc_reg == CW'(BLINK_DIV - 1)) begin
      presc_reg <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign blink_rd   = blink_reg;
  assign blink_dark = blink_reg & {NUM_DIGITS{phase_reg}};
`else
  // Without the blink option nothing depends on BLINK_DIV; this empty
  // block only keeps the parameter referenced.
  if (BLINK_DIV < 2) begin : g_blink_div_unused
  end

  assign blink_rd   = '0;
  assign blink_dark = '0;
`endif

  // -------------------------------------------------------------------------
  // Read path. The mux sees register contents before any same-cycle write,
  // so a simultaneous read/write returns the old value.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[VW-1:0]         = value_reg;
      2'd1:    rd_mux[NUM_DIGITS-1:0] = blank_reg;
      2'd2:    rd_mux[NUM_DIGITS-1:0] = blink_rd;
      default: rd_mux[1:0]            = {lzs_reg, en_reg};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero suppression: walking down from the top digit, a digit is
  // suppressed while it and every digit above it hold zero. Digit 0 always
  // shows so a zero value still displays "0".
  // -------------------------------------------------------------------------
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (value_reg[4*k +: 4] == 4'h0);
      suppress[k] = lzs_reg && zero_run && (k != 0);
    end
  end

  // Per-digit decode; any dark reason overrides the glyph, so BLANK wins
  // over blink automatically.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic       dark;
    logic [3:0] nib;
    assign nib  = value_reg[4*gi +: 4];
    assign dark = !en_reg || blank_reg[gi] || suppress[gi] || blink_dark[gi];
    assign hex_next[7*gi +: 7] = dark ? 7'h7F : seg_decode(nib);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_out <= '1;
    end else begin
      hex_out <= hex_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_display_ctrl
//   Drives an 8-digit and a 4-digit instance from one shared bus. A
//   behavioural model (register contents plus an edge count since the last
//   phase restart) predicts hex_out and readdata for both; a compare process
//   checks them on every falling edge. Directed checks with literal values
//   pin the model to the expected glyphs and readback values.
// ---------------------------------------------------------------------------
module tb_hex_display_ctrl;

  localparam int DIV = 4;
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic [1:0]  address   = 2'd0;
  logic        write     = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        read      = 1'b0;

  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [55:0] hex_a;
  logic [27:0] hex_b;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(DIV)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(rd_a), .hex_out(hex_a)
  );

  hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(DIV)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(rd_b), .hex_out(hex_b)
  );

  // ---------------------------------------------------------------- model
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_n [2] = '{8, 4};
  logic [31:0] m_value [2];
  logic [31:0] m_blank [2];
  logic [31:0] m_blink [2];
  bit          m_en [2];
  bit          m_lzs [2];
  int          m_t [2];     // edges since the last prescaler restart
  logic [55:0] exp_hex [2];
  logic [31:0] exp_rd [2];

  function automatic logic [31:0] low_mask(input int bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  function automatic logic [55:0] model_display(input int i);
    logic [55:0] r;
    logic [3:0]  nib;
    bit          lead, ph, dark;
    r  = '1;
    ph = ((m_t[i] / DIV) % 2) == 1;
    for (int k = 0; k < m_n[i]; k++) begin
      nib  = 4'((m_value[i] >> (4 * k)) & 32'hF);
      lead = (k > 0) && m_lzs[i] && ((m_value[i] >> (4 * k)) == 32'd0);
      dark = !m_en[i] || m_blank[i][k] || lead || (BLINK_ON && m_blink[i][k] && ph);
      r[7*k +: 7] = dark ? 7'h7F : glyph[nib];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int i, input logic [1:0] a);
    case (a)
      2'd0:    return m_value[i];
      2'd1:    return m_blank[i];
      2'd2:    return m_blink[i];
      default: return {30'd0, m_lzs[i], m_en[i]};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_value[i] = 32'd0;
        m_blank[i] = 32'd0;
        m_blink[i] = 32'd0;
        m_en[i]    = 1'b1;
        m_lzs[i]   = 1'b0;
        m_t[i]     = 0;
        exp_hex[i] = '1;
        exp_rd[i]  = 32'd0;
      end else begin
        exp_hex[i] = model_display(i);
        if (read) exp_rd[i] = model_read(i, address);
        m_t[i]++;
        if (write) begin
          case (address)
            2'd0: m_value[i] = writedata & low_mask(4 * m_n[i]);
            2'd1: m_blank[i] = writedata & low_mask(m_n[i]);
            2'd2: if (BLINK_ON) m_blink[i] = writedata & low_mask(m_n[i]);
            default: begin
              m_en[i]  = writedata[0];
              m_lzs[i] = writedata[1];
              if (BLINK_ON && writedata[2]) m_t[i] = 0;
            end
          endcase
        end
      end
    end
  end

  // ------------------------------------------------------------ checking
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_hex_a", {8'd0, hex_a}, {8'd0, exp_hex[0]});
      check("model_hex_b", {36'd0, hex_b}, {36'd0, exp_hex[1][27:0]});
      check("model_rd_a", {32'd0, rd_a}, {32'd0, exp_rd[0]});
      check("model_rd_b", {32'd0, rd_b}, {32'd0, exp_rd[1]});
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    read    = 1'b1;
    tick();
    read = 1'b0;
    $display("read  addr=%0d a=%h b=%h", a, rd_a, rd_b);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check_en = 1'b1;
    check("reset_hex_a", {8'd0, hex_a}, {8'd0, {56{1'b1}}});
    check("reset_rd_a", {32'd0, rd_a}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check("post_reset_zero_a", {8'd0, hex_a}, {8'd0, {8{7'h40}}});
    check("post_reset_zero_b", {36'd0, hex_b}, {36'd0, {4{7'h40}}});

    // Leading-zero suppression with a mixed value.
    bus_write(2'd0, 32'h0000_12AF);
    bus_write(2'd3, 32'h3);
    tick();
    check("lzs_12af_a", {8'd0, hex_a},
          {8'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E});
    check("lzs_12af_b", {36'd0, hex_b}, {36'd0, 7'h79, 7'h24, 7'h08, 7'h0E});

    // Value zero: only digit 0 remains lit.
    bus_write(2'd0, 32'h0);
    tick();
    check("lzs_zero_a", {8'd0, hex_a}, {8'd0, {7{7'h7F}}, 7'h40});
    check("lzs_zero_b", {36'd0, hex_b}, {36'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // BLANK readback and effect.
    bus_write(2'd3, 32'h1);
    bus_write(2'd0, 32'h8765_4321);
    bus_write(2'd1, 32'h5);
    bus_read(2'd1);
    check("blank_rd_a", {32'd0, rd_a}, 64'h5);
    check("blank_rd_b", {32'd0, rd_b}, 64'h5);
    check("blank_hex_a", {8'd0, hex_a},
          {8'd0, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h7F, 7'h24, 7'h7F});
    check("blank_hex_b", {36'd0, hex_b}, {36'd0, 7'h19, 7'h7F, 7'h24, 7'h7F});

    // PHASE_RST is a strobe and reads as 0.
    bus_write(2'd3, 32'h7);
    bus_read(2'd3);
    check("ctrl_rd_a", {32'd0, rd_a}, 64'h3);

    // Simultaneous read and write returns the old value.
    address = 2'd0; writedata = 32'hDEAD_BEEF; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    $display("rdwr  addr=0 data=deadbeef a=%h b=%h", rd_a, rd_b);
    check("rdwr_old_a", {32'd0, rd_a}, 64'h8765_4321);
    check("rdwr_old_b", {32'd0, rd_b}, 64'h4321);
    bus_read(2'd0);
    check("rdwr_new_a", {32'd0, rd_a}, 64'hDEAD_BEEF);
    check("rdwr_new_b", {32'd0, rd_b}, 64'hBEEF);

    // BLINK width masking.
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2);
    check("blink_rd_a", {32'd0, rd_a}, BLINK_ON ? 64'hFF : 64'h0);
    check("blink_rd_b", {32'd0, rd_b}, BLINK_ON ? 64'hF : 64'h0);

    // EN=0 darkens everything.
    bus_write(2'd3, 32'h0);
    tick();
    check("en_off_a", {8'd0, hex_a}, {8'd0, {56{1'b1}}});
    check("en_off_b", {36'd0, hex_b}, {36'd0, {28{1'b1}}});

    // Blink cadence on digit 0 after a phase restart.
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h1);
    bus_write(2'd0, 32'h8);
    bus_write(2'd3, 32'h5);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("blink_cycle_a", {57'd0, hex_a[6:0]}, (BLINK_ON && k > 4) ? 64'h7F : 64'h00);
      check("blink_cycle_b", {57'd0, hex_b[6:0]}, (BLINK_ON && k > 4) ? 64'h7F : 64'h00);
    end
    repeat (5) tick();
    bus_write(2'd3, 32'h5);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("blink_restart_a", {57'd0, hex_a[6:0]}, (BLINK_ON && k == 5) ? 64'h7F : 64'h00);
    end

    // BLANK dominates blink.
    bus_write(2'd1, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("blank_over_blink_a", {57'd0, hex_a[6:0]}, 64'h7F);
    end

    // Reset asserted between edges during a write.
    address = 2'd0; writedata = 32'hFFFF_FFFF; write = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    $display("reset during write addr=0 data=ffffffff");
    check("mid_reset_hex_a", {8'd0, hex_a}, {8'd0, {56{1'b1}}});
    check("mid_reset_hex_b", {36'd0, hex_b}, {36'd0, {28{1'b1}}});
    check("mid_reset_rd_a", {32'd0, rd_a}, 64'd0);
    write = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus_read(2'd0);
    check("mid_reset_value_a", {32'd0, rd_a}, 64'd0);
    check("mid_reset_glyph_a", {8'd0, hex_a}, {8'd0, {8{7'h40}}});

    repeat (2) tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
